eeprom_page_arbiter: RTL and testbench

- Shares one I2C EEPROM controller between two requesters and sequences complete page transactions on it.
- Each requester issues either a page write of PAGE_BYTES bytes or a page read of PAGE_BYTES bytes.
- The block arbitrates round-robin, drives the controller's start/enable/address/data/index inputs, and collects read bytes.
- After every page write it enforces the EEPROM internal write-cycle time (tWR) before it starts another transaction.

---
 rtl/eeprom_page_arbiter_if.sv | 28 ++
 rtl/eeprom_page_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_eeprom_page_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_page_arbiter_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// eeprom_page_arbiter_if : arbiter <-> I2C EEPROM controller signal bundle
// Rev 1.0
// ============================================================================
interface eeprom_page_arbiter_if;
  logic        i2c_start;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;
  logic [7:0]  index;
  logic        i2c_end;
  logic [7:0]  rd_data;
  logic        ack_4_flag;

  modport master (
    output i2c_start, wr_en, rd_en, byte_addr, wr_data, index,
    input  i2c_end, rd_data, ack_4_flag
  );

  modport slave (
    input  i2c_start, wr_en, rd_en, byte_addr, wr_data, index,
    output i2c_end, rd_data, ack_4_flag
  );
endinterface
`default_nettype wire

// File: rtl/eeprom_page_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// eeprom_page_arbiter : round-robin page read/write sequencer for one shared
//                       I2C EEPROM controller, with post-write tWR hold-off
// Rev 1.0
// ============================================================================
module eeprom_page_arbiter #(
  parameter int PAGE_BYTES  = 4,
  parameter int TWR_CYC     = 250000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [15:0]             addr0,
  input  logic [8*PAGE_BYTES-1:0] wdata0,
  output logic                    done0,
  output logic                    err0,
  output logic [8*PAGE_BYTES-1:0] rdata0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [15:0]             addr1,
  input  logic [8*PAGE_BYTES-1:0] wdata1,
  output logic                    done1,
  output logic                    err1,
  output logic [8*PAGE_BYTES-1:0] rdata1,
  output logic [1:0]              gnt,
  output logic                    busy,
  eeprom_page_arbiter_if.master   bus
);
  localparam int          PW          = 8 * PAGE_BYTES;
  localparam logic [5:0]  c_page_cnt  = 6'(PAGE_BYTES);
  localparam logic [7:0]  c_last_idx  = 8'(PAGE_BYTES - 1);
  localparam logic [15:0] c_addr_mask = 16'(PAGE_BYTES - 1);
  localparam logic [31:0] c_twr_last  = 32'(TWR_CYC - 1);
  localparam logic [31:0] c_to_last   = 32'(TIMEOUT_CYC - 1);

  generate
    if (PAGE_BYTES != 1 && PAGE_BYTES != 2 && PAGE_BYTES != 4 &&
        PAGE_BYTES != 8 && PAGE_BYTES != 16) begin : g_bad_page_bytes
      $error("PAGE_BYTES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_XFER, S_TWR, S_DONE
  } state_t;

  state_t        r_state;
  logic          r_last, r_owner, r_we, r_err;
  logic          r_start, r_wr_en, r_rd_en;
  logic [1:0]    r_gnt;
  logic [15:0]   r_addr;
  logic [PW-1:0] r_page, r_rbuf, w_rbuf_next;
  logic [7:0]    r_index, w_wr_byte;
  logic [5:0]    r_cnt, w_cnt_next;
  logic [31:0]   r_tmr;
  logic          w_pick1, w_take, w_overrun, w_short, w_err_next;

  // Port 1 wins only when port 0 is idle or port 0 was served last.
  assign w_pick1 = req1 && (!req0 || !r_last);

  // A strobe is accepted until a full page has been counted; later ones are overruns.
  assign w_take     = bus.ack_4_flag && (r_cnt < c_page_cnt);
  assign w_overrun  = bus.ack_4_flag && !(r_cnt < c_page_cnt);
  assign w_cnt_next = r_cnt + 6'(w_take);
  assign w_short    = bus.i2c_end && (w_cnt_next < c_page_cnt);
  assign w_err_next = r_err | w_overrun | w_short;

  always_comb begin
    w_rbuf_next = r_rbuf;
    w_wr_byte   = 8'd0;
    for (int k = 0; k < PAGE_BYTES; k++) begin
      if (r_index == 8'(k)) begin
        w_wr_byte = r_page[8*k +: 8];
        if (w_take && !r_we) w_rbuf_next[8*k +: 8] = bus.rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_gnt    <= 2'b00;
      r_addr   <= 16'd0;
      r_page   <= '0;
      r_rbuf   <= '0;
      r_index  <= 8'd0;
      r_cnt    <= 6'd0;
      r_tmr    <= 32'd0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_pick1;
            r_last  <= w_pick1;
            r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
            r_we    <= w_pick1 ? we1 : we0;
            r_addr  <= w_pick1 ? addr1 : addr0;
            r_page  <= w_pick1 ? wdata1 : wdata0;
            r_index <= 8'd0;
            r_cnt   <= 6'd0;
            r_err   <= 1'b0;
            r_tmr   <= 32'd0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Page writes must not straddle a page boundary.
          if (r_we && ((r_addr & c_addr_mask) != 16'd0)) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_start <= 1'b1;
            r_wr_en <= r_we;
            r_rd_en <= !r_we;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_tmr   <= 32'd0;
          r_state <= S_XFER;
        end
        S_XFER: begin
          r_rbuf <= w_rbuf_next;
          r_err  <= w_err_next;
          if (w_take) begin
            r_cnt <= w_cnt_next;
            if (r_index < c_last_idx) r_index <= r_index + 8'd1;
          end
          if (bus.i2c_end) begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_tmr   <= 32'd0;
            if (r_we) begin
              r_state <= S_TWR;
            end else begin
              r_state <= S_DONE;
              if (!w_err_next) begin
                if (r_owner) rdata1 <= w_rbuf_next;
                else         rdata0 <= w_rbuf_next;
              end
            end
          end else if (r_tmr == c_to_last) begin
            r_err   <= 1'b1;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr + 32'd1;
          end
        end
        S_TWR: begin
          if (r_tmr == c_twr_last) r_state <= S_DONE;
          else                     r_tmr   <= r_tmr + 32'd1;
        end
        S_DONE: begin
          r_gnt   <= 2'b00;
          r_index <= 8'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Done lines track the one-cycle DONE state so the requester can drop req right after.
  assign done0 = (r_state == S_DONE) && !r_owner;
  assign done1 = (r_state == S_DONE) && r_owner;
  assign err0  = done0 && r_err;
  assign err1  = done1 && r_err;
  assign gnt   = r_gnt;
  assign busy  = (r_state != S_IDLE);

  assign bus.i2c_start = r_start;
  assign bus.wr_en     = r_wr_en;
  assign bus.rd_en     = r_rd_en;
  assign bus.byte_addr = r_addr;
  assign bus.index     = r_index;
  assign bus.wr_data   = w_wr_byte;
endmodule
`default_nettype wire

// File: tb/tb_eeprom_page_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_eeprom_page_arbiter : directed self-checking bench for eeprom_page_arbiter
// Rev 1.0
// ============================================================================
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_eeprom_page_arbiter;
  localparam int PB  = 4;
  localparam int TWR = 20;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0]   addr0 = 16'd0, addr1 = 16'd0;
  logic [8*PB-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, err0, done1, err1, busy;
  logic [8*PB-1:0] rdata0, rdata1;
  logic [1:0]    gnt;

  eeprom_page_arbiter_if bus ();

  eeprom_page_arbiter #(
    .PAGE_BYTES (PB),
    .TWR_CYC    (TWR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .we0   (we0),
    .addr0 (addr0),
    .wdata0(wdata0),
    .done0 (done0),
    .err0  (err0),
    .rdata0(rdata0),
    .req1  (req1),
    .we1   (we1),
    .addr1 (addr1),
    .wdata1(wdata1),
    .done1 (done1),
    .err1  (err1),
    .rdata1(rdata1),
    .gnt   (gnt),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  int done0_cnt = 0;

  always @(negedge clk) begin
    if (bus.i2c_start) start_cnt <= start_cnt + 1;
    if (bus.wr_en)     wr_cnt    <= wr_cnt + 1;
    if (done0)         done0_cnt <= done0_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if ((bus.wr_en & bus.rd_en) !== 1'b0) begin
        errors++;
        $error("FAIL mon: wr_en and rd_en high together");
      end
      if ((busy === 1'b0) && (gnt !== 2'b00)) begin
        errors++;
        $error("FAIL mon: gnt=%0b while not busy", gnt);
      end
      if ((bus.i2c_start === 1'b1) && (gnt === 2'b00)) begin
        errors++;
        $error("FAIL mon: i2c_start without grant");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit port, input int limit, output int n);
    n = 0;
    while (!(port ? done1 : done0) && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [5];
    int n, s0, w0, d0;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'h55;
    bus.i2c_end = 1'b0; bus.ack_4_flag = 1'b0; bus.rd_data = 8'h00;

    tick(); tick();
    `CHK("rst_gnt", gnt, 2'b00);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_done0", done0, 1'b0);
    `CHK("rst_start", bus.i2c_start, 1'b0);
    `CHK("rst_wr_en", bus.wr_en, 1'b0);
    `CHK("rst_wr_data", bus.wr_data, 8'h00);
    `CHK("rst_rdata0", rdata0, 32'h0);
    rst = 1'b0;
    tick();

    // Port 0 page write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 32'h44332211;
    tick();
    `CHK("w_gnt", gnt, 2'b01);
    `CHK("w_busy", busy, 1'b1);
    tick();
    `CHK("w_start", bus.i2c_start, 1'b1);
    `CHK("w_wr_en", bus.wr_en, 1'b1);
    `CHK("w_rd_en", bus.rd_en, 1'b0);
    `CHK("w_addr", bus.byte_addr, 16'h0010);
    tick();
    `CHK("w_start_pulse", bus.i2c_start, 1'b0);
    for (int k = 0; k < 4; k++) begin
      `CHK("w_byte", bus.wr_data, pat[k]);
      bus.ack_4_flag = 1'b1;
      tick();
      bus.ack_4_flag = 1'b0;
    end
    `CHK("w_index_end", bus.index, 8'd3);
    bus.i2c_end = 1'b1;
    tick();
    bus.i2c_end = 1'b0;
    `CHK("w_wr_en_off", bus.wr_en, 1'b0);
    `CHK("w_gnt_twr", gnt, 2'b01);
    wait_done(1'b0, 60, n);
    `CHK("w_twr_cycles", n, TWR);
    `CHK("w_err0", err0, 1'b0);
    req0 = 1'b0;
    tick();
    `CHK("w_idle", busy, 1'b0);
    `CHK("w_gnt_clr", gnt, 2'b00);

    // Port 1 page read; last strobe coincides with i2c_end.
    w0 = wr_cnt;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    tick();
    `CHK("r_gnt", gnt, 2'b10);
    tick();
    `CHK("r_start", bus.i2c_start, 1'b1);
    `CHK("r_rd_en", bus.rd_en, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.rd_data = pat[k]; bus.ack_4_flag = 1'b1;
      if (k == 3) bus.i2c_end = 1'b1;
      tick();
      bus.ack_4_flag = 1'b0; bus.i2c_end = 1'b0;
    end
    `CHK("r_done1", done1, 1'b1);
    `CHK("r_err1", err1, 1'b0);
    `CHK("r_rdata1", rdata1, 32'h44332211);
    `CHK("r_rd_en_off", bus.rd_en, 1'b0);
    `CHK("r_no_wr_en", wr_cnt - w0, 0);
    req1 = 1'b0;
    tick();

    // Misaligned write: rejected without bus activity.
    s0 = start_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0013;
    tick();
    tick();
    `CHK("mis_done0", done0, 1'b1);
    `CHK("mis_err0", err0, 1'b1);
    req0 = 1'b0;
    tick(); tick();
    `CHK("mis_no_start", start_cnt - s0, 0);

    // Short read: two strobes then end.
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      bus.rd_data = 8'hA0 + 8'(k); bus.ack_4_flag = 1'b1;
      tick();
      bus.ack_4_flag = 1'b0;
    end
    bus.i2c_end = 1'b1;
    tick();
    bus.i2c_end = 1'b0;
    `CHK("short_done1", done1, 1'b1);
    `CHK("short_err1", err1, 1'b1);
    `CHK("short_rdata1", rdata1, 32'h44332211);
    req1 = 1'b0;
    tick();

    // Overrun read: five strobes.
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      bus.rd_data = pat[k] ^ 8'hFF; bus.ack_4_flag = 1'b1;
      tick();
      bus.ack_4_flag = 1'b0;
    end
    `CHK("ovr_index", bus.index, 8'd3);
    bus.i2c_end = 1'b1;
    tick();
    bus.i2c_end = 1'b0;
    `CHK("ovr_err1", err1, 1'b1);
    `CHK("ovr_rdata1", rdata1, 32'h44332211);
    req1 = 1'b0;
    tick();

    // Timeout: no i2c_end.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    tick(); tick(); tick();
    wait_done(1'b0, 150, n);
    `CHK("to_cycles", n, TO);
    `CHK("to_err0", err0, 1'b1);
    `CHK("to_rd_en", bus.rd_en, 1'b0);
    req0 = 1'b0;
    tick();

    // Reset in the middle of a write transfer.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 32'hDDCCBBAA;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      bus.ack_4_flag = 1'b1;
      tick();
      bus.ack_4_flag = 1'b0;
    end
    `CHK("mid_wr_data", bus.wr_data, 8'hCC);
    rst = 1'b1; req0 = 1'b0;
    tick();
    `CHK("mid_gnt", gnt, 2'b00);
    `CHK("mid_busy", busy, 1'b0);
    `CHK("mid_wr_en", bus.wr_en, 1'b0);
    `CHK("mid_index", bus.index, 8'd0);
    `CHK("mid_wr_data0", bus.wr_data, 8'h00);
    `CHK("mid_rdata1", rdata1, 32'h0);
    rst = 1'b0;
    d0 = done0_cnt;
    tick(); tick(); tick();
    `CHK("mid_no_done", done0_cnt - d0, 0);

    // Round robin with both requests held (misaligned writes finish quickly).
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0001;
    tick();
    `CHK("rr_first", gnt, 2'b01);
    tick();
    `CHK("rr_done0", done0, 1'b1);
    tick();
    `CHK("rr_idle", busy, 1'b0);
    tick();
    `CHK("rr_second", gnt, 2'b10);
    tick();
    `CHK("rr_done1", done1, 1'b1);
    tick();
    tick();
    `CHK("rr_third", gnt, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    `CHK("rr_end_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`undef CHK
`default_nettype wire
